// File: rtl/psum_accum.sv
// rtl/psum_accum.sv - column partial-sum accumulator with valid/ready drain port
//
// Sits below the last PE row. Adds partial sums from successive weight passes
// into a per-address accumulator bank, then streams the bank out on request,
// clearing each entry as it is accepted.
//
// Ports:
//   CLK, RSTn                 clock (rising edge), asynchronous active-low reset
//   Psum_In / Addr_P_In       signed partial sum and its bank entry
//   Valid_P_In                beat accepted when nonzero
//   First_In                  with a valid beat: overwrite instead of accumulate
//   Drain_Req                 one-cycle request to stream the bank out
//   Out_Valid/Out_Ready       output handshake
//   Out_Addr/Out_Data         entry index and signed accumulated value
//   Busy                      high while draining
//   Drain_Done                one-cycle pulse after the last beat is accepted
//   Sat_Flag / Drop_Flag      sticky: accumulation saturated / beat dropped in drain

module psum_accum #(
  parameter int BIT_PSUM  = 32,
  parameter int BIT_ADDR  = 4,
  parameter int BIT_VALID = 1,
  parameter int BIT_ACC   = 40
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [BIT_PSUM-1:0]  Psum_In,
  input  logic [BIT_ADDR-1:0]  Addr_P_In,
  input  logic [BIT_VALID-1:0] Valid_P_In,
  input  logic                 First_In,
  input  logic                 Drain_Req,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [BIT_ADDR-1:0]  Out_Addr,
  output logic [BIT_ACC-1:0]   Out_Data,
  output logic                 Busy,
  output logic                 Drain_Done,
  output logic                 Sat_Flag,
  output logic                 Drop_Flag
);

  localparam int DEPTH = 2 ** BIT_ADDR;

  typedef enum logic {
    ST_ACC   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [BIT_ADDR-1:0] rd_ptr;
  logic [BIT_ACC-1:0]  acc [DEPTH];

  logic                beat_valid;
  logic                fire;
  logic                last_entry;
  logic [BIT_ACC-1:0]  acc_cur;
  logic [BIT_ACC-1:0]  psum_ext;
  logic [BIT_ACC:0]    sum_wide;
  logic                sum_ovf;
  logic [BIT_ACC-1:0]  sum_sat;

  assign beat_valid = |Valid_P_In;
  assign fire       = (state == ST_DRAIN) && Out_Ready;
  assign last_entry = (rd_ptr == BIT_ADDR'(DEPTH - 1));

  // Read-modify-write happens in one cycle, so a beat at the next edge to the
  // same address already sees this one without any forwarding.
  assign acc_cur  = acc[Addr_P_In];
  assign psum_ext = BIT_ACC'($signed(Psum_In));

  // One guard bit: the two top bits disagree exactly when the sum left range.
  assign sum_wide = {acc_cur[BIT_ACC-1], acc_cur} + {psum_ext[BIT_ACC-1], psum_ext};
  assign sum_ovf  = sum_wide[BIT_ACC] ^ sum_wide[BIT_ACC-1];
  always_comb begin
    sum_sat = sum_wide[BIT_ACC-1:0];
    if (sum_ovf) begin
      sum_sat = sum_wide[BIT_ACC] ? {1'b1, {(BIT_ACC-1){1'b0}}}
                                  : {1'b0, {(BIT_ACC-1){1'b1}}};
    end
  end

  // Outputs are decoded from registered state only.
  assign Out_Valid = (state == ST_DRAIN);
  assign Busy      = (state == ST_DRAIN);
  assign Out_Addr  = rd_ptr;
  assign Out_Data  = (state == ST_DRAIN) ? acc[rd_ptr] : '0;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state <= ST_ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:   if (Drain_Req) state_nxt = ST_DRAIN;
      ST_DRAIN: if (fire && last_entry) state_nxt = ST_ACC;
      default:  state_nxt = ST_ACC;
    endcase
  end

  // rd_ptr wraps to zero on the last accepted beat, which keeps Out_Addr at
  // zero while accumulating.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_ptr     <= '0;
      Drain_Done <= 1'b0;
      Sat_Flag   <= 1'b0;
      Drop_Flag  <= 1'b0;
    end else begin
      Drain_Done <= fire && last_entry;
      if (state == ST_ACC) begin
        if (Drain_Req) rd_ptr <= '0;
        if (beat_valid && !First_In && sum_ovf) Sat_Flag <= 1'b1;
      end else begin
        if (fire) rd_ptr <= rd_ptr + BIT_ADDR'(1);
        if (beat_valid) Drop_Flag <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) acc[i] <= '0;
    end else if (state == ST_ACC) begin
      if (beat_valid) acc[Addr_P_In] <= First_In ? psum_ext : sum_sat;
    end else if (fire) begin
      acc[rd_ptr] <= '0;
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
// tb/tb_psum_accum.sv - directed self-checking bench for psum_accum

module tb_psum_accum;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RSTn;
  logic [31:0] Psum_In;
  logic [3:0]  Addr_P_In;
  logic [0:0]  Valid_P_In;
  logic        First_In, Drain_Req, Out_Ready;
  logic        Out_Valid;
  logic [3:0]  Out_Addr;
  logic [39:0] Out_Data;
  logic        Busy, Drain_Done, Sat_Flag, Drop_Flag;

  logic [7:0]  s_psum;
  logic [1:0]  s_addr;
  logic [0:0]  s_valid;
  logic        s_first, s_req, s_ready;
  logic        s_out_valid;
  logic [1:0]  s_out_addr;
  logic [7:0]  s_out_data;
  logic        s_busy, s_done, s_sat, s_drop;

  psum_accum dut (
    .CLK(CLK), .RSTn(RSTn),
    .Psum_In(Psum_In), .Addr_P_In(Addr_P_In), .Valid_P_In(Valid_P_In),
    .First_In(First_In), .Drain_Req(Drain_Req),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready),
    .Out_Addr(Out_Addr), .Out_Data(Out_Data),
    .Busy(Busy), .Drain_Done(Drain_Done),
    .Sat_Flag(Sat_Flag), .Drop_Flag(Drop_Flag)
  );

  psum_accum #(.BIT_PSUM(8), .BIT_ADDR(2), .BIT_VALID(1), .BIT_ACC(8)) dut8 (
    .CLK(CLK), .RSTn(RSTn),
    .Psum_In(s_psum), .Addr_P_In(s_addr), .Valid_P_In(s_valid),
    .First_In(s_first), .Drain_Req(s_req),
    .Out_Valid(s_out_valid), .Out_Ready(s_ready),
    .Out_Addr(s_out_addr), .Out_Data(s_out_data),
    .Busy(s_busy), .Drain_Done(s_done),
    .Sat_Flag(s_sat), .Drop_Flag(s_drop)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  longint exp_bank [16];

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 16; i++) exp_bank[i] = 0;
  endtask

  task automatic beat(input int a, input int d, input bit f);
    Valid_P_In = 1'b1;
    Addr_P_In  = a[3:0];
    Psum_In    = d;
    First_In   = f;
    tick();
    Valid_P_In = 1'b0;
    First_In   = 1'b0;
  endtask

  task automatic beat8(input int a, input int d, input bit f);
    s_valid = 1'b1;
    s_addr  = a[1:0];
    s_psum  = d[7:0];
    s_first = f;
    tick();
    s_valid = 1'b0;
    s_first = 1'b0;
  endtask

  task automatic req_drain();
    Drain_Req = 1'b1;
    tick();
    Drain_Req = 1'b0;
    check_eq("start_busy", Busy, 1);
    check_eq("start_valid", Out_Valid, 1);
    check_eq("start_addr", Out_Addr, 0);
  endtask

  // stall=1 drives Out_Ready as 1,0,0,1,0,0,...
  task automatic run_drain(input bit stall, input bit inj_drop, input bit rereq);
    int beats = 0;
    int cyc   = 0;
    while (beats < 16 && cyc < 200) begin
      Out_Ready  = stall ? (cyc % 3 == 0) : 1'b1;
      Valid_P_In = inj_drop && (cyc == 0);
      Addr_P_In  = 4'd1;
      Psum_In    = 32'd7;
      First_In   = 1'b0;
      Drain_Req  = rereq && (cyc == 6);
      check_eq("drain_valid", Out_Valid, 1);
      check_eq($sformatf("drain_addr[%0d]", beats), Out_Addr, beats);
      check_eq($sformatf("drain_data[%0d]", beats), $signed(Out_Data), exp_bank[beats]);
      if (Out_Ready) beats++;
      cyc++;
      tick();
    end
    Valid_P_In = 1'b0;
    Drain_Req  = 1'b0;
    Out_Ready  = 1'b0;
    check_eq("drain_beats", beats, 16);
    check_eq("done_pulse", Drain_Done, 1);
    check_eq("end_busy", Busy, 0);
    check_eq("end_valid", Out_Valid, 0);
    tick();
    check_eq("done_once", Drain_Done, 0);
  endtask

  task automatic drain8(input int exp0);
    s_req = 1'b1;
    tick();
    s_req   = 1'b0;
    s_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("s8_valid", s_out_valid, 1);
      check_eq("s8_addr", s_out_addr, i);
      check_eq($sformatf("s8_data[%0d]", i), $signed(s_out_data), (i == 0) ? exp0 : 0);
      tick();
    end
    s_ready = 1'b0;
    check_eq("s8_done", s_done, 1);
  endtask

  initial begin
    RSTn = 1'b0;
    Psum_In = '0; Addr_P_In = '0; Valid_P_In = '0; First_In = 1'b0;
    Drain_Req = 1'b0; Out_Ready = 1'b0;
    s_psum = '0; s_addr = '0; s_valid = '0; s_first = 1'b0; s_req = 1'b0; s_ready = 1'b0;
    clear_exp();
    repeat (2) tick();

    check_eq("rst_valid", Out_Valid, 0);
    check_eq("rst_addr", Out_Addr, 0);
    check_eq("rst_data", Out_Data, 0);
    check_eq("rst_busy", Busy, 0);
    check_eq("rst_done", Drain_Done, 0);
    check_eq("rst_sat", Sat_Flag, 0);
    check_eq("rst_drop", Drop_Flag, 0);
    RSTn = 1'b1;
    tick();

    // Back-to-back accumulation to one address: 100 - 30 + 5 = 75
    beat(3, 100, 1'b1);
    beat(3, -30, 1'b0);
    beat(3, 5, 1'b0);
    First_In = 1'b1; Addr_P_In = 4'd3; Psum_In = 32'd999;
    tick();
    First_In = 1'b0;
    exp_bank[3] = 75;
    req_drain();
    run_drain(1'b0, 1'b0, 1'b0);
    check_eq("no_sat", Sat_Flag, 0);
    check_eq("no_drop", Drop_Flag, 0);

    // Stalled drain, then an immediate second drain of an all-zero bank
    clear_exp();
    beat(5, -12, 1'b1);
    beat(5, 20, 1'b0);
    exp_bank[5] = 8;
    req_drain();
    run_drain(1'b1, 1'b0, 1'b0);
    clear_exp();
    req_drain();
    run_drain(1'b0, 1'b0, 1'b0);

    // Beat during drain is dropped; repeated request is ignored
    beat(1, 4, 1'b1);
    exp_bank[1] = 4;
    req_drain();
    run_drain(1'b0, 1'b1, 1'b1);
    check_eq("drop_flag", Drop_Flag, 1);

    // Next pass: addr 1 restarts from zero; beat with Drain_Req is included
    clear_exp();
    beat(1, 2, 1'b0);
    beat(2, 1, 1'b1);
    Valid_P_In = 1'b1; Addr_P_In = 4'd2; Psum_In = 32'd9; First_In = 1'b0;
    Drain_Req = 1'b1;
    tick();
    Valid_P_In = 1'b0; Drain_Req = 1'b0;
    check_eq("sim_busy", Busy, 1);
    check_eq("sim_addr", Out_Addr, 0);
    exp_bank[1] = 2;
    exp_bank[2] = 10;
    run_drain(1'b0, 1'b0, 1'b0);
    check_eq("drop_sticky", Drop_Flag, 1);

    // Narrow instance saturation
    beat8(0, 100, 1'b1);
    check_eq("s8_sat_pre", s_sat, 0);
    beat8(0, 100, 1'b0);
    check_eq("s8_sat_pos", s_sat, 1);
    drain8(127);
    beat8(0, -100, 1'b1);
    beat8(0, -100, 1'b0);
    drain8(-128);
    check_eq("s8_sat_sticky", s_sat, 1);

    // Asynchronous reset mid-drain at rd_ptr = 5
    clear_exp();
    beat(9, 33, 1'b1);
    beat(5, 11, 1'b1);
    req_drain();
    Out_Ready = 1'b1;
    repeat (5) tick();
    check_eq("mid_addr", Out_Addr, 5);
    check_eq("mid_data", $signed(Out_Data), 11);
    #2;
    RSTn = 1'b0;
    #1;
    check_eq("arst_valid", Out_Valid, 0);
    check_eq("arst_busy", Busy, 0);
    check_eq("arst_addr", Out_Addr, 0);
    check_eq("arst_data", Out_Data, 0);
    check_eq("arst_drop", Drop_Flag, 0);
    check_eq("arst_sat8", s_sat, 0);
    Out_Ready = 1'b0;
    tick();
    check_eq("arst_hold", Out_Valid, 0);
    RSTn = 1'b1;
    tick();
    req_drain();
    run_drain(1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/psum_accum.md
# psum_accum

Column-level partial-sum accumulator placed directly below the last PE row of the systolic array. It consumes the bottom PE's `Psum_Out` / `Addr_P_Out` / `Valid_P_Out` stream and sums partial sums from successive weight passes into a per-address accumulator bank. On request it drains the finished results through a valid/ready output port to the output buffer, clearing each entry as it leaves.

## Interface
- `BIT_PSUM`, 32, width of incoming signed partial sum (matches PE psum width)
- `BIT_ADDR`, 4, psum address width; bank depth `DEPTH = 2**BIT_ADDR`
- `BIT_VALID`, 1, width of incoming valid field
- `BIT_ACC`, 40, signed accumulator width (`BIT_ACC >= BIT_PSUM`)

Ports:
- `CLK`  in  1  single clock, all state on rising edge
- `RSTn`  in  1  asynchronous, active-low reset
- `Psum_In`  in  BIT_PSUM  signed partial sum from bottom PE
- `Addr_P_In`  in  BIT_ADDR  accumulator entry for `Psum_In`
- `Valid_P_In`  in  BIT_VALID  psum valid; beat accepted when nonzero
- `First_In`  in  1  with valid beat: overwrite entry instead of adding (first weight pass)
- `Drain_Req`  in  1  one-cycle request to stream out the bank
- `Out_Valid`  out  1  output beat valid
- `Out_Ready`  in  1  downstream accepts beat
- `Out_Addr`  out  BIT_ADDR  entry index of current beat
- `Out_Data`  out  BIT_ACC  signed accumulated value
- `Busy`  out  1  high while in DRAIN
- `Drain_Done`  out  1  one-cycle pulse after last beat accepted
- `Sat_Flag`  out  1  sticky: any accumulation saturated
- `Drop_Flag`  out  1  sticky: valid psum arrived during DRAIN and was discarded

## Operation
- Storage: `DEPTH` flop registers `acc[0..DEPTH-1]`, BIT_ACC signed each; single-cycle read-modify-write, so back-to-back beats to the same address accumulate correctly with no stall.
- FSM states: ACC, DRAIN.
  - ACC: on valid beat, `acc[Addr_P_In] <= First_In ? sext(Psum_In) : sat(acc[Addr_P_In] + sext(Psum_In))`. `Drain_Req` -> DRAIN, read pointer `rd_ptr <= 0`.
  - DRAIN: `Out_Valid=1`, `Out_Addr=rd_ptr`, `Out_Data=acc[rd_ptr]`. On `Out_Valid && Out_Ready`: `acc[rd_ptr] <= 0`, `rd_ptr++`. Handshake at `rd_ptr==DEPTH-1` -> ACC, with `Drain_Done` pulsed the following cycle.
- Arithmetic: `Psum_In` sign-extended to BIT_ACC; sum computed at BIT_ACC+1 and saturated to `[-2^(BIT_ACC-1), 2^(BIT_ACC-1)-1]`; saturation sets `Sat_Flag`. Overwrite (`First_In`) never saturates.
- Simultaneous valid beat and `Drain_Req` in ACC: beat is applied that cycle; drained values include it.
- Valid beat during DRAIN: discarded, `acc` unchanged, `Drop_Flag` set.
- `Drain_Req` during DRAIN: ignored.
- `First_In` without valid: ignored.
- Sticky flags clear only on reset.

## Timing
- Reset (`RSTn` low, async): state ACC, all `acc=0`, `rd_ptr=0`, `Out_Valid=0`, `Out_Addr=0`, `Out_Data=0`, `Busy=0`, `Drain_Done=0`, `Sat_Flag=0`, `Drop_Flag=0`. Reset mid-drain aborts immediately; no further beats.
- Accumulate latency: beat sampled at edge N is visible in `acc` after edge N; a beat at N+1 to the same address sees it.
- `Drain_Req` sampled at edge N -> `Busy=1`, `Out_Valid=1`, `Out_Addr=0` after edge N.
- Outputs depend only on registered state (no combinational input-to-output path). `Out_Addr`/`Out_Data` are held stable while `Out_Ready` is low.
- Full drain with `Out_Ready` held high: DEPTH cycles of `Out_Valid`. `Busy` falls and `Drain_Done` pulses for one cycle after the edge accepting the last beat. A valid psum may be accepted in that same cycle.

## Test plan
- Reset, then beats (addr 3, 100, First=1), (addr 3, -30), (addr 3, 5) on consecutive cycles, then `Drain_Req` -> beat addr 3 carries 75; every other address carries 0; `Drain_Done` pulses once after 16 beats.
- Drain with `Out_Ready` toggled 1,0,0,1,… -> values and addresses hold while stalled; no beat duplicated or skipped. A second drain immediately after returns all zeros.
- BIT_ACC=BIT_PSUM=8: addr 0 gets 100 (First) then +100 -> drained value 127, `Sat_Flag=1`; repeat with -100,-100 -> -128.
- Valid beat (addr 1, 7) during DRAIN -> discarded, `Drop_Flag=1`; the next pass's drained addr 1 excludes 7.
- Valid beat (addr 2, 9) in the same cycle as `Drain_Req` -> drained addr 2 includes 9. `Drain_Req` repeated mid-drain -> no restart.
- Assert `RSTn` low mid-drain at `rd_ptr=5` -> outputs return to reset values asynchronously; after release the bank reads all zeros.
